redirect_ctrl: RTL and testbench

//  Sequences control-flow redirects from the execute-stage branch unit and the CSR/trap unit into fetch.

---
 rtl/redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_redirect_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/redirect_ctrl.sv
// Redirect sequencer between EXU/CSR and fetch: arbitrates branch and trap redirects,
// flushes IF/ID, stalls EX, drains an outstanding ibus fetch and holds the new PC until accepted.
module redirect_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic             br_redirect,
    input  logic [XLEN-1:0]  br_target,
    input  logic             trap_redirect,
    input  logic [XLEN-1:0]  trap_target,
    input  logic             ifetch_busy,
    input  logic             ifetch_resp,
    input  logic             pc_ready,
    output logic             redirect_req,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             ex_stall,
    output logic             discard_resp,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;
    logic               flush_ifid_q, flush_ifid_d;
    logic               misalign_q, misalign_d;
    logic               redirect_req_q, redirect_req_d;
    logic               ex_stall_q, ex_stall_d;

    logic               br_req;
    logic               capture;
    logic [XLEN-1:0]    cap_target;

    // Next-state, capture and pulse generation
    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        redirect_cnt_d = redirect_cnt_q;
        flush_ifid_d   = 1'b0;
        misalign_d     = 1'b0;
        discard_resp   = 1'b0;
        capture        = 1'b0;

        br_req     = br_valid & br_redirect;
        cap_target = trap_redirect ? trap_target : br_target;

        case (state_q)
            ST_IDLE: begin
                if (trap_redirect | br_req) begin
                    capture = 1'b1;
                    state_d = (ifetch_busy & ~ifetch_resp) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                discard_resp = ifetch_resp;
                capture      = trap_redirect;
                if (ifetch_resp) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A late trap supersedes the pending PC even if fetch accepts this cycle
                if (trap_redirect) begin
                    capture = 1'b1;
                end else if (pc_ready) begin
                    state_d        = ST_IDLE;
                    redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            redirect_pc_d = cap_target;
            flush_ifid_d  = 1'b1;
            misalign_d    = cap_target[1];
        end

        redirect_req_d = (state_d == ST_ISSUE);
        ex_stall_d     = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            redirect_pc_q  <= '0;
            redirect_cnt_q <= '0;
            flush_ifid_q   <= 1'b0;
            misalign_q     <= 1'b0;
            redirect_req_q <= 1'b0;
            ex_stall_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            redirect_pc_q  <= redirect_pc_d;
            redirect_cnt_q <= redirect_cnt_d;
            flush_ifid_q   <= flush_ifid_d;
            misalign_q     <= misalign_d;
            redirect_req_q <= redirect_req_d;
            ex_stall_q     <= ex_stall_d;
        end
    end

    assign redirect_req = redirect_req_q;
    assign redirect_pc  = redirect_pc_q;
    assign flush_ifid   = flush_ifid_q;
    assign ex_stall     = ex_stall_q;
    assign misalign     = misalign_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed and randomized bench for redirect_ctrl against a transaction-level reference model.
module tb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_valid, br_redirect, trap_redirect;
    logic [63:0] br_target, trap_target;
    logic        ifetch_busy, ifetch_resp, pc_ready;

    logic        redirect_req, flush_ifid, ex_stall, discard_resp, misalign;
    logic [63:0] redirect_pc;
    logic [31:0] redirect_cnt;

    logic        w_req, w_flush, w_stall, w_discard, w_mis;
    logic [63:0] w_pc;
    logic [2:0]  w_cnt;

    always #5 clk = ~clk;

    redirect_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_redirect(br_redirect), .br_target(br_target),
        .trap_redirect(trap_redirect), .trap_target(trap_target),
        .ifetch_busy(ifetch_busy), .ifetch_resp(ifetch_resp), .pc_ready(pc_ready),
        .redirect_req(redirect_req), .redirect_pc(redirect_pc), .flush_ifid(flush_ifid),
        .ex_stall(ex_stall), .discard_resp(discard_resp), .misalign(misalign),
        .redirect_cnt(redirect_cnt)
    );

    // Narrow-counter instance on the same stimulus to exercise counter wrap
    redirect_ctrl #(.XLEN(64), .CNT_W(3)) u_wrap (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_redirect(br_redirect), .br_target(br_target),
        .trap_redirect(trap_redirect), .trap_target(trap_target),
        .ifetch_busy(ifetch_busy), .ifetch_resp(ifetch_resp), .pc_ready(pc_ready),
        .redirect_req(w_req), .redirect_pc(w_pc), .flush_ifid(w_flush),
        .ex_stall(w_stall), .discard_resp(w_discard), .misalign(w_mis),
        .redirect_cnt(w_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_br_while_pending = 0;

    // Reference model: a redirect is either absent, waiting for the ibus to settle, or offered
    bit          m_pending  = 1'b0;
    bit          m_waiting  = 1'b0;
    bit          m_flush    = 1'b0;
    bit          m_mis      = 1'b0;
    logic [63:0] m_pc       = '0;
    logic [31:0] m_cnt      = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic take(input logic [63:0] tgt);
        m_pc    = tgt;
        m_flush = 1'b1;
        m_mis   = tgt[1];
    endtask

    task automatic model_edge();
        bit br;
        br      = br_valid & br_redirect;
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (reset) begin
            m_pending = 1'b0; m_waiting = 1'b0; m_pc = '0; m_cnt = '0;
        end else if (!m_pending) begin
            if (trap_redirect || br) begin
                take(trap_redirect ? trap_target : br_target);
                m_pending = 1'b1;
                m_waiting = ifetch_busy && !ifetch_resp;
            end
        end else begin
            if (br) n_br_while_pending++;
            if (m_waiting) begin
                if (trap_redirect) take(trap_target);
                if (ifetch_resp) m_waiting = 1'b0;
            end else if (trap_redirect) begin
                take(trap_target);
            end else if (pc_ready) begin
                m_pending = 1'b0;
                m_cnt     = m_cnt + 32'd1;
            end
        end
    endtask

    // One clock: check outputs mid-cycle with current inputs, then advance model on the edge
    task automatic cycle();
        #1;
        chk("redirect_req", redirect_req, m_pending && !m_waiting);
        chk("redirect_pc",  redirect_pc,  m_pc);
        chk("flush_ifid",   flush_ifid,   m_flush);
        chk("ex_stall",     ex_stall,     m_pending);
        chk("discard_resp", discard_resp, m_pending && m_waiting && ifetch_resp);
        chk("misalign",     misalign,     m_mis);
        chk("redirect_cnt", redirect_cnt, m_cnt);
        chk("wrap_cnt",     w_cnt,        64'(m_cnt[2:0]));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit bv, input bit br, input logic [63:0] bt,
                         input bit tr, input logic [63:0] tt,
                         input bit busy, input bit resp, input bit rdy);
        br_valid = bv; br_redirect = br; br_target = bt;
        trap_redirect = tr; trap_target = tt;
        ifetch_busy = busy; ifetch_resp = resp; pc_ready = rdy;
        cycle();
    endtask

    task automatic idle(input bit rdy);
        drive(0, 0, 64'h0, 0, 64'h0, 0, 0, rdy);
    endtask

    initial begin
        reset = 1'b1;
        br_valid = 0; br_redirect = 0; br_target = '0;
        trap_redirect = 0; trap_target = '0;
        ifetch_busy = 0; ifetch_resp = 0; pc_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", redirect_req, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_cnt", redirect_cnt, 0);
        idle(0);
        reset = 1'b0;
        idle(0);

        // Branch with fetch idle, accepted on first offer
        drive(1, 1, 64'h8000_0100, 0, 64'h0, 0, 0, 1);
        chk("t1_req", redirect_req, 1);
        chk("t1_flush", flush_ifid, 1);
        idle(1);
        chk("t1_cnt", redirect_cnt, 1);
        chk("t1_idle", ex_stall, 0);
        idle(0);

        // Branch while an ibus fetch is outstanding
        drive(1, 1, 64'h8000_1000, 0, 64'h0, 1, 0, 0);
        drive(0, 0, 64'h0, 0, 64'h0, 1, 0, 0);
        drive(0, 0, 64'h0, 0, 64'h0, 1, 0, 0);
        chk("t2_no_req", redirect_req, 0);
        drive(0, 0, 64'h0, 0, 64'h0, 1, 1, 0);
        chk("t2_req", redirect_req, 1);
        idle(1);
        chk("t2_cnt", redirect_cnt, 2);

        // Trap and branch in the same cycle
        drive(1, 1, 64'h8000_0200, 1, 64'h8000_0004, 0, 0, 0);
        idle(1);
        idle(0);
        chk("t3_pc", redirect_pc, 64'h8000_0004);
        chk("t3_cnt", redirect_cnt, 3);

        // Trap overrides a pending branch in ISSUE
        drive(1, 1, 64'h8000_0300, 0, 64'h0, 0, 0, 0);
        drive(0, 0, 64'h0, 1, 64'h8000_0008, 0, 0, 0);
        chk("t4_pc", redirect_pc, 64'h8000_0008);
        chk("t4_flush2", flush_ifid, 1);
        chk("t4_cnt_hold", redirect_cnt, 3);
        drive(0, 0, 64'h0, 1, 64'h8000_000c, 0, 0, 1);
        chk("t4_trap_wins", redirect_cnt, 3);
        idle(1);
        idle(0);
        chk("t4_cnt", redirect_cnt, 4);

        // Misaligned target, then counter wrap on the narrow instance
        drive(1, 1, 64'h8000_0102, 0, 64'h0, 0, 0, 0);
        chk("t5_mis", misalign, 1);
        idle(1);
        chk("t5_mis_pulse", misalign, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 64'h0, 1, 64'h8000_0400 + 64'(i * 4), 0, 0, 1);
            idle(1);
        end
        idle(0);
        chk("t5_wide_cnt", redirect_cnt, 8);
        chk("t5_wrap_cnt", w_cnt, 0);

        // Reset in the middle of ISSUE
        drive(1, 1, 64'h8000_0500, 0, 64'h0, 0, 0, 0);
        reset = 1'b1;
        idle(0);
        reset = 1'b0;
        chk("t6_req", redirect_req, 0);
        chk("t6_pc", redirect_pc, 0);
        chk("t6_cnt", redirect_cnt, 0);
        idle(1);
        idle(1);
        chk("t6_ignored", redirect_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [63:0] bt, tt;
            bt = {$urandom, $urandom} & ~64'h1;
            tt = {$urandom, $urandom} & ~64'h1;
            reset = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1), bt,
                  ($urandom_range(0, 7) == 0), tt,
                  $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 1));
        end
        reset = 1'b0;
        idle(1);

        $display("note: %0d branch requests arrived while a redirect was pending", n_br_while_pending);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
